// File: rtl/layer_activation_buffer_if.sv
// Strobe, data and status bundle between the master control path, the
// activation datapath and the ping-pong activation buffer.
interface layer_activation_buffer_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              output_wr_en;
  logic              output_shft_en;
  logic              output_sel;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] act_out;
  logic [5:0]        rd_len;
  logic [5:0]        wr_cnt;
  logic              bank_sel;
  logic              ovf;

  modport master (
    output start, res_valid, res_data, output_wr_en, output_shft_en,
           output_sel, ext_data,
    input  act_out, rd_len, wr_cnt, bank_sel, ovf
  );

  modport slave (
    input  start, res_valid, res_data, output_wr_en, output_shft_en,
           output_sel, ext_data,
    output act_out, rd_len, wr_cnt, bank_sel, ovf
  );
endinterface

// File: rtl/layer_activation_buffer.sv
// Ping-pong activation store: one bank collects the current layer's neuron
// results while the other replays the previous layer's outputs word by word.
module layer_activation_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  layer_activation_buffer_if.slave bus
);
  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] DEPTH_C = 7'(DEPTH);

  logic [DATA_W-1:0] mem [2*DEPTH];

  logic [5:0]        wr_cnt, rd_len, rd_ptr;
  logic              bank_sel, ovf;
  logic [DATA_W-1:0] act_out;

  logic [5:0]        wr_cnt_nxt, rd_len_nxt, rd_ptr_nxt, cnt_written;
  logic              bank_sel_nxt, ovf_nxt, write_ok;
  logic [AW:0]       wr_addr, rd_addr;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    write_ok     = bus.res_valid && ({1'b0, wr_cnt} < DEPTH_C);
    cnt_written  = write_ok ? wr_cnt + 6'd1 : wr_cnt;
    wr_cnt_nxt   = cnt_written;
    rd_len_nxt   = rd_len;
    rd_ptr_nxt   = rd_ptr;
    bank_sel_nxt = bank_sel;
    ovf_nxt      = ovf | (bus.res_valid & ~write_ok);

    // A swap commits any same-cycle write first and overrides a shift.
    if (bus.output_wr_en) begin
      rd_len_nxt   = cnt_written;
      bank_sel_nxt = ~bank_sel;
      wr_cnt_nxt   = '0;
      rd_ptr_nxt   = '0;
    end else if (bus.output_shft_en && (rd_len != 6'd0)) begin
      rd_ptr_nxt = (rd_ptr == rd_len - 6'd1) ? 6'd0 : rd_ptr + 6'd1;
    end

    wr_addr = {bank_sel, wr_cnt[AW-1:0]};
    rd_addr = {~bank_sel_nxt, rd_ptr_nxt[AW-1:0]};

    // On a swap the new read bank is the one being written this cycle.
    rd_data = (write_ok && (wr_addr == rd_addr)) ? bus.res_data : mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst_n && !bus.start && write_ok) begin
      mem[wr_addr] <= bus.res_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.start) begin
      wr_cnt   <= '0;
      rd_len   <= '0;
      rd_ptr   <= '0;
      bank_sel <= 1'b0;
      ovf      <= 1'b0;
      act_out  <= '0;
    end else begin
      wr_cnt   <= wr_cnt_nxt;
      rd_len   <= rd_len_nxt;
      rd_ptr   <= rd_ptr_nxt;
      bank_sel <= bank_sel_nxt;
      ovf      <= ovf_nxt;
      act_out  <= bus.output_sel ? rd_data : bus.ext_data;
    end
  end

  assign bus.act_out  = act_out;
  assign bus.rd_len   = rd_len;
  assign bus.wr_cnt   = wr_cnt;
  assign bus.bank_sel = bank_sel;
  assign bus.ovf      = ovf;
endmodule

// File: tb/tb_layer_activation_buffer.sv
// Scoreboard bench for layer_activation_buffer: a behavioural model predicts
// every registered output per cycle and the results are compared after each edge.
module tb_layer_activation_buffer;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  layer_activation_buffer_if #(.DATA_W(DATA_W)) bus();

  layer_activation_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          chk;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  int          m_wr, m_ptr, m_len;
  bit          m_bank, m_ovf;
  logic [15:0] m_store [2][DEPTH];
  bit          m_known [2][DEPTH];

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes, advance the model, then compare after the edge.
  task automatic applyStimulus(input bit rstn, input bit st, input bit rv,
                               input logic [15:0] rd, input bit wr, input bit sh,
                               input bit sel, input logic [15:0] ext);
    exp_t e;
    @(negedge clk);
    rst_n              = rstn;
    bus.start          = st;
    bus.res_valid      = rv;
    bus.res_data       = rd;
    bus.output_wr_en   = wr;
    bus.output_shft_en = sh;
    bus.output_sel     = sel;
    bus.ext_data       = ext;

    if (!rstn || st) begin
      m_wr = 0; m_ptr = 0; m_len = 0; m_bank = 0; m_ovf = 0;
      e.chk = 1; e.val = 16'h0000;
    end else begin
      if (rv) begin
        if (m_wr < DEPTH) begin
          m_store[m_bank][m_wr] = rd;
          m_known[m_bank][m_wr] = 1;
          m_wr++;
        end else begin
          m_ovf = 1;
        end
      end
      if (wr) begin
        m_len  = m_wr;
        m_bank = ~m_bank;
        m_wr   = 0;
        m_ptr  = 0;
      end else if (sh && m_len != 0) begin
        m_ptr = (m_ptr + 1) % m_len;
      end
      if (sel) begin
        e.chk = m_known[!m_bank][m_ptr];
        e.val = m_store[!m_bank][m_ptr];
      end else begin
        e.chk = 1;
        e.val = ext;
      end
    end
    sb.push_back(e);

    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk) checkOutput("act_out", bus.act_out, e.val);
    checkOutput("wr_cnt",   bus.wr_cnt,   m_wr);
    checkOutput("rd_len",   bus.rd_len,   m_len);
    checkOutput("bank_sel", bus.bank_sel, m_bank);
    checkOutput("ovf",      bus.ovf,      m_ovf);
  endtask

  initial begin
    bus.start = 0; bus.res_valid = 0; bus.res_data = 0; bus.output_wr_en = 0;
    bus.output_shft_en = 0; bus.output_sel = 0; bus.ext_data = 0;

    // Reset for two cycles, then a start pulse.
    repeat (2) applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, 16'h1234);
    applyStimulus(1, 1, 0, 16'h0, 0, 0, 0, 16'h0);
    checkOutput("reset_act", bus.act_out, 16'h0);

    // Fill three words, swap, replay with wrap.
    applyStimulus(1, 0, 1, 16'h0011, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 1, 16'h0022, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 1, 16'h0033, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 1, 0, 0, 16'h0);
    checkOutput("swap_rd_len", bus.rd_len, 6'd3);
    checkOutput("swap_bank", bus.bank_sel, 1'b1);
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 1, 16'h0);
    checkOutput("first_word", bus.act_out, 16'h0011);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("shift1", bus.act_out, 16'h0022);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("shift2", bus.act_out, 16'h0033);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("shift_wrap", bus.act_out, 16'h0011);

    // External path.
    applyStimulus(1, 0, 0, 16'h0, 0, 0, 0, 16'h7FFF);
    checkOutput("ext_path", bus.act_out, 16'h7FFF);

    // Write coinciding with swap lands in the old write bank.
    applyStimulus(1, 0, 1, 16'h0044, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 1, 16'h0055, 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 1, 16'h00AA, 1, 0, 0, 16'h0);
    checkOutput("simul_rd_len", bus.rd_len, 6'd3);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("simul_word2", bus.act_out, 16'h00AA);

    // Shift and swap together: pointer restarts at 0.
    applyStimulus(1, 0, 1, 16'h0101, 0, 1, 1, 16'h0);
    applyStimulus(1, 0, 1, 16'h0102, 0, 0, 1, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 1, 1, 1, 16'h0);
    checkOutput("shift_swap_ptr0", bus.act_out, 16'h0101);

    // Overflow after restart.
    applyStimulus(1, 1, 0, 16'h0, 0, 0, 0, 16'h0);
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1, 0, 1, 16'(16'h0200 + i), 0, 0, 0, 16'h0);
    checkOutput("ovf_wr_cnt", bus.wr_cnt, 6'd32);
    checkOutput("ovf_flag", bus.ovf, 1'b1);
    applyStimulus(1, 0, 0, 16'h0, 1, 0, 1, 16'h0);
    checkOutput("ovf_rd_len", bus.rd_len, 6'd32);
    for (int i = 0; i < DEPTH - 1; i++)
      applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("ovf_last_word", bus.act_out, 16'h021F);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("ovf_wrap", bus.act_out, 16'h0200);
    applyStimulus(1, 1, 0, 16'h0, 0, 0, 0, 16'h0);
    checkOutput("ovf_cleared", bus.ovf, 1'b0);

    // Mid-operation reset with rd_ptr=2 and wr_cnt=5.
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 0, 1, 16'(16'h0300 + i), 0, 0, 0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 1, 0, 1, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 0, 1, 16'(16'h0400 + i), 0, 0, 1, 16'h0);
    checkOutput("pre_reset_wr_cnt", bus.wr_cnt, 6'd5);
    checkOutput("pre_reset_word2", bus.act_out, 16'h0302);
    applyStimulus(0, 0, 0, 16'h0, 0, 0, 1, 16'h0);
    checkOutput("mid_reset_bank", bus.bank_sel, 1'b0);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("empty_shift_word0", bus.act_out, 16'h0400);
    applyStimulus(1, 0, 0, 16'h0, 0, 1, 1, 16'h0);
    checkOutput("empty_shift_again", bus.act_out, 16'h0400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
